// File: rtl/signed_minmax_tracker_if.sv
// Sample stream and tracked-window status bundle for signed_minmax_tracker.
interface signed_minmax_tracker_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8
);
  logic [WIDTH-1:0]     I;
  logic                 I_valid;
  logic                 CLR;
  logic [WIDTH-1:0]     O_min;
  logic [WIDTH-1:0]     O_max;
  logic [CNT_WIDTH-1:0] O_count;
  logic                 O_valid;
  logic                 O_sat;
  logic                 O_new_min;
  logic                 O_new_max;

  // Producer side: drives samples, observes window status.
  modport master (
    output I, I_valid, CLR,
    input  O_min, O_max, O_count, O_valid, O_sat, O_new_min, O_new_max
  );

  // Tracker side.
  modport slave (
    input  I, I_valid, CLR,
    output O_min, O_max, O_count, O_valid, O_sat, O_new_min, O_new_max
  );
endinterface

// File: rtl/signed_minmax_tracker.sv
// Running signed min/max tracker with saturating sample count and
// one-cycle new-extreme pulses. All outputs come straight from flops.
module signed_minmax_tracker #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 8
) (
  input logic                  CLK,
  input logic                  ASYNCRESET,
  signed_minmax_tracker_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_TRACKING  = 2'd1,
    ST_SATURATED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     min_q, min_d;
  logic [WIDTH-1:0]     max_q, max_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 sat_q, sat_d;
  logic                 new_min_q, new_min_d;
  logic                 new_max_q, new_max_d;

  logic                 min_le_c;
  logic                 max_le_c;

  // Signed-LE comparators: sample vs current min, current max vs sample.
  assign min_le_c = $signed(bus.I) <= $signed(min_q);
  assign max_le_c = $signed(max_q) <= $signed(bus.I);

  // Next-state and next-output decode.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    max_d     = max_q;
    cnt_d     = cnt_q;
    new_min_d = 1'b0;
    new_max_d = 1'b0;

    if (bus.CLR && !bus.I_valid) begin
      state_d = ST_EMPTY;
      min_d   = '0;
      max_d   = '0;
      cnt_d   = '0;
    end else if (bus.I_valid) begin
      if (bus.CLR || (state_q == ST_EMPTY)) begin
        // First sample of a window seeds both extremes without pulsing.
        min_d   = bus.I;
        max_d   = bus.I;
        cnt_d   = CNT_ONE;
        state_d = (CNT_ONE == CNT_MAX) ? ST_SATURATED : ST_TRACKING;
      end else begin
        if (min_le_c) min_d = bus.I;
        if (max_le_c) max_d = bus.I;
        new_min_d = min_le_c && (bus.I != min_q);
        new_max_d = max_le_c && (bus.I != max_q);
        if (state_q == ST_TRACKING) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == CNT_MAX) state_d = ST_SATURATED;
        end
      end
    end

    valid_d = (state_d != ST_EMPTY);
    sat_d   = (state_d == ST_SATURATED);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q   <= ST_EMPTY;
      min_q     <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      new_min_q <= 1'b0;
      new_max_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      sat_q     <= sat_d;
      new_min_q <= new_min_d;
      new_max_q <= new_max_d;
    end
  end

  assign bus.O_min     = min_q;
  assign bus.O_max     = max_q;
  assign bus.O_count   = cnt_q;
  assign bus.O_valid   = valid_q;
  assign bus.O_sat     = sat_q;
  assign bus.O_new_min = new_min_q;
  assign bus.O_new_max = new_max_q;

endmodule

// File: doc/signed_minmax_tracker.md
Name: signed_minmax_tracker

Overview:
- Streaming stage that sits directly downstream of the signed less-or-equal comparator.
- Accepts a stream of signed samples and keeps the running signed minimum and maximum since the last clear, plus a saturating sample count.
- Makes both window comparisons with the signed-LE relation, one instance for the min compare and one for the max compare.
- Registered outputs feed threshold/alarm logic and status registers.

Parameters:
- WIDTH, 8, sample width in bits; two's-complement signed.
- CNT_WIDTH, 8, width of the sample counter; saturates at 2^CNT_WIDTH-1.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- ASYNCRESET  input  1  asynchronous, active-high reset.
- I  input  WIDTH  signed sample.
- I_valid  input  1  sample qualifier; I is sampled only when high.
- CLR  input  1  synchronous clear of tracked window.
- O_min  output  WIDTH  running signed minimum.
- O_max  output  WIDTH  running signed maximum.
- O_count  output  CNT_WIDTH  accepted samples since clear, saturating.
- O_valid  output  1  high when at least one sample has been accepted since clear.
- O_sat  output  1  high when O_count has reached 2^CNT_WIDTH-1.
- O_new_min  output  1  one-cycle pulse: last accepted sample was strictly below the previous min.
- O_new_max  output  1  one-cycle pulse: last accepted sample was strictly above the previous max.

Behaviour:
- Reset (ASYNCRESET high, any time, including mid-stream):
  - State goes to EMPTY immediately.
  - O_min=0, O_max=0, O_count=0; O_valid, O_sat, O_new_min and O_new_max all 0.
  - Deassertion is synchronised externally; the first edge after deassertion behaves normally.
- State machine, 3 states (EMPTY, TRACKING, SATURATED):
  - EMPTY: O_valid=0. On I_valid, load O_min=O_max=I and O_count=1, then go to TRACKING. No new_min/new_max pulse on the first sample.
  - TRACKING: on I_valid, update min and max (rules below) and increment O_count. When the increment makes O_count = 2^CNT_WIDTH-1, go to SATURATED.
  - SATURATED: min and max keep updating; O_count holds at all-ones; O_sat=1.
  - CLR high in any state returns to EMPTY, with one exception: CLR and I_valid together go to TRACKING with the sample loaded as the first sample (count=1, no pulses).
- Compare rules (signed, full WIDTH, no extension needed):
  - Min: O_min <= I when $signed(I) <= $signed(O_min). O_new_min=1 only if additionally I != O_min, i.e. strictly less.
  - Max: O_max <= I when $signed(O_max) <= $signed(I). O_new_max=1 only if strictly greater.
  - Equal samples update the registers with an identical value and produce no pulse.
- Latency: a sample presented at edge N is reflected in all outputs after edge N. Pulses last exactly one cycle and are 0 on any cycle without an accepted sample.
- I_valid low: all state holds and the pulses are 0.
- A single sample can raise both pulses only if it is the first sample after TRACKING entry via compare. Impossible by construction: first-sample load never pulses.
- CLR with I_valid low: O_min and O_max return to 0 and O_count to 0; outputs show the reset values on the next cycle.
- Boundary values:
  - -2^(WIDTH-1) (0x80) must be recognised as the minimum.
  - 2^(WIDTH-1)-1 (0x7F) must be recognised as the maximum.
  - No unsigned comparison anywhere.

Test Plan:
- Reset, then hold I_valid=0 for 5 cycles -> O_valid=0, O_min=O_max=0x00, O_count=0, no pulses.
- Samples 0x05, 0xFB(-5), 0x7F, 0x80(-128) on consecutive cycles:
  - Outputs after each edge (min/max): 05/05; FB/05 with new_min; FB/7F with new_max; 80/7F with new_min.
  - O_count 1, 2, 3, 4.
- Repeat sample 0x10 three times after clear -> min=max=0x10, count=3, no pulses after the first.
- CLR with I_valid=1 and I=0xF0 while tracking min=0x80 and max=0x7F -> next cycle min=max=0xF0, count=1, O_valid=1, no pulses.
- CNT_WIDTH=3, feed 9 samples -> O_count reaches 7 on the 7th sample, O_sat=1, count stays 7. A later sample 0x81 below the current min still updates O_min and pulses new_min.
- Assert ASYNCRESET between clock edges mid-stream -> outputs return to reset values before the next edge. The first sample after release is loaded as the first sample.
